// File: rtl/universal_register_if.sv
// Control and observation bundle for universal_register: the master side drives
// the operation controls, and the slave side returns the register state.
interface universal_register_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             ser_out;
  logic             changed;

  modport master (
    output en, mode, d, j, k, ser_in,
    input  q, qbar, ser_out, changed
  );

  modport slave (
    input  en, mode, d, j, k, ser_in,
    output q, qbar, ser_out, changed
  );

endinterface

// File: rtl/universal_register.sv
// Multi-mode WIDTH-bit register: hold, load, JK, toggle, shift and rotate.
// It also provides a registered shift-out bit and a one-cycle "value changed" flag.
module universal_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                   clk,
  input logic                   reset,
  universal_register_if.slave   bus
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_JK     = 3'b010,
    MODE_TOGGLE = 3'b011,
    MODE_SHL    = 3'b100,
    MODE_SHR    = 3'b101,
    MODE_ROL    = 3'b110,
    MODE_ROR    = 3'b111
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;

  assign mode = mode_e'(bus.mode);

  // A one-bit register has no neighbour bits: shifts take ser_in, and rotates leave q unchanged.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign shl_v = bus.ser_in;
      assign shr_v = bus.ser_in;
      assign rol_v = q_q;
      assign ror_v = q_q;
    end else begin : g_wide
      assign shl_v = {q_q[WIDTH-2:0], bus.ser_in};
      assign shr_v = {bus.ser_in, q_q[WIDTH-1:1]};
      assign rol_v = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      assign ror_v = {q_q[0], q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    q_d       = q_q;
    ser_out_d = ser_out_q;
    if (bus.en) begin
      unique case (mode)
        MODE_HOLD:   q_d = q_q;
        MODE_LOAD:   q_d = bus.d;
        MODE_JK:     q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        MODE_TOGGLE: q_d = q_q ^ bus.d;
        MODE_SHL: begin
          q_d       = shl_v;
          ser_out_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d       = shr_v;
          ser_out_d = q_q[0];
        end
        MODE_ROL: begin
          q_d       = rol_v;
          ser_out_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d       = ror_v;
          ser_out_d = q_q[0];
        end
      endcase
    end
    changed_d = (q_d != q_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset is asynchronous (in the sensitivity list).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= RESET_VALUE;
      ser_out_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      changed_q <= changed_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.qbar    = ~q_q;
  assign bus.ser_out = ser_out_q;
  assign bus.changed = changed_q;

endmodule
